// File: rtl/msrv32_lsu_ctrl_if.sv
// ----------------------------------------------------------------------------
// msrv32_lsu_ctrl_if
// Bundles the execute-stage request side and the data-memory bus side of the
// msrv32 load/store unit.
//   master : view used by the LSU itself (drives lsu_ready/lsu_done/lsu_err/
//            lsu_rdata and the mem_* request signals)
//   slave  : view used by the environment (execute stage + data memory)
// Signals:
//   lsu_valid_in, lsu_is_store_in, lsu_funct3_in[2:0], lsu_addr_in[31:0],
//   lsu_wdata_in[31:0]              request from execute stage
//   lsu_ready_out                   LSU can accept a request
//   mem_req_out, mem_we_out, mem_addr_out[31:0], mem_wmask_out[3:0],
//   mem_wdata_out[31:0]             bus request
//   mem_ack_in, mem_rdata_in[31:0]  bus completion / read data
//   lsu_done_out, lsu_err_out[1:0], lsu_rdata_out[31:0]  access result
// ----------------------------------------------------------------------------
interface msrv32_lsu_ctrl_if;
    logic        lsu_valid_in;
    logic        lsu_ready_out;
    logic        lsu_is_store_in;
    logic [2:0]  lsu_funct3_in;
    logic [31:0] lsu_addr_in;
    logic [31:0] lsu_wdata_in;
    logic        mem_req_out;
    logic        mem_we_out;
    logic [31:0] mem_addr_out;
    logic [3:0]  mem_wmask_out;
    logic [31:0] mem_wdata_out;
    logic        mem_ack_in;
    logic [31:0] mem_rdata_in;
    logic        lsu_done_out;
    logic [1:0]  lsu_err_out;
    logic [31:0] lsu_rdata_out;

    modport master (
        input  lsu_valid_in, lsu_is_store_in, lsu_funct3_in, lsu_addr_in, lsu_wdata_in,
               mem_ack_in, mem_rdata_in,
        output lsu_ready_out, mem_req_out, mem_we_out, mem_addr_out, mem_wmask_out,
               mem_wdata_out, lsu_done_out, lsu_err_out, lsu_rdata_out
    );

    modport slave (
        output lsu_valid_in, lsu_is_store_in, lsu_funct3_in, lsu_addr_in, lsu_wdata_in,
               mem_ack_in, mem_rdata_in,
        input  lsu_ready_out, mem_req_out, mem_we_out, mem_addr_out, mem_wmask_out,
               mem_wdata_out, lsu_done_out, lsu_err_out, lsu_rdata_out
    );
endinterface

// File: rtl/msrv32_lsu_ctrl.sv
// ----------------------------------------------------------------------------
// msrv32_lsu_ctrl
// Load/store unit for the msrv32 execute stage. Takes the ALU sum as the
// effective address, performs one data-memory access over a req/ack bus,
// lane-aligns store data/byte enables and sign/zero-extends load data.
// Reports misaligned (01), bus timeout (10) and illegal funct3 (11) errors.
// Ports:
//   ms_riscv32_mp_clk_in    clock, rising edge
//   ms_riscv32_mp_rst_n_in  synchronous active-low reset
//   bus                     msrv32_lsu_ctrl_if.master (request, memory bus,
//                           result signals)
// Parameter:
//   TIMEOUT_CYCLES          cycles req may stay high without ack (>=2)
// ----------------------------------------------------------------------------
module msrv32_lsu_ctrl #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                     ms_riscv32_mp_clk_in,
    input  logic                     ms_riscv32_mp_rst_n_in,
    msrv32_lsu_ctrl_if.master        bus
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP,
        ERR
    } state_t;

    state_t      state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic        store_q, store_n;
    logic [2:0]  funct3_q, funct3_n;
    logic [1:0]  addr_lo_q, addr_lo_n;
    logic        req_q, req_n;
    logic        we_q, we_n;
    logic [31:0] maddr_q, maddr_n;
    logic [3:0]  mask_q, mask_n;
    logic [31:0] mwdata_q, mwdata_n;
    logic        done_q, done_n;
    logic [1:0]  err_q, err_n;
    logic [31:0] rdata_q, rdata_n;

    logic        illegal;
    logic        misaligned;
    logic [3:0]  st_mask;
    logic [31:0] st_data;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] load_ext;

    // Decode of the request currently presented on the input side; only used
    // at the accept edge.
    always_comb begin
        illegal    = 1'b0;
        misaligned = 1'b0;
        st_mask    = 4'b0000;
        st_data    = 32'h0;
        case (bus.lsu_funct3_in)
            3'b011, 3'b110, 3'b111: illegal = 1'b1;
            3'b100, 3'b101:         illegal = bus.lsu_is_store_in;
            default:                illegal = 1'b0;
        endcase
        if (bus.lsu_funct3_in[1:0] == 2'b01)
            misaligned = bus.lsu_addr_in[0];
        else if (bus.lsu_funct3_in[1:0] == 2'b10)
            misaligned = (bus.lsu_addr_in[1:0] != 2'b00);
        if (bus.lsu_is_store_in) begin
            case (bus.lsu_funct3_in[1:0])
                2'b00: begin
                    st_mask = 4'b0001 << bus.lsu_addr_in[1:0];
                    st_data = {4{bus.lsu_wdata_in[7:0]}};
                end
                2'b01: begin
                    st_mask = 4'b0011 << bus.lsu_addr_in[1:0];
                    st_data = {2{bus.lsu_wdata_in[15:0]}};
                end
                default: begin
                    st_mask = 4'b1111;
                    st_data = bus.lsu_wdata_in;
                end
            endcase
        end
    end

    // Lane selection and extension of the returned read word, using the
    // access width and low address bits captured at accept time.
    always_comb begin
        lane_byte = 8'h00;
        case (addr_lo_q)
            2'b00: lane_byte = bus.mem_rdata_in[7:0];
            2'b01: lane_byte = bus.mem_rdata_in[15:8];
            2'b10: lane_byte = bus.mem_rdata_in[23:16];
            2'b11: lane_byte = bus.mem_rdata_in[31:24];
            default: lane_byte = 8'h00;
        endcase
        lane_half = addr_lo_q[1] ? bus.mem_rdata_in[31:16] : bus.mem_rdata_in[15:0];
        case (funct3_q)
            3'b000:  load_ext = {{24{lane_byte[7]}}, lane_byte};
            3'b001:  load_ext = {{16{lane_half[15]}}, lane_half};
            3'b100:  load_ext = {24'h0, lane_byte};
            3'b101:  load_ext = {16'h0, lane_half};
            default: load_ext = bus.mem_rdata_in;
        endcase
    end

    // Next-state logic. Every output is registered, so this block computes
    // the next value of each output register alongside the state.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        store_n   = store_q;
        funct3_n  = funct3_q;
        addr_lo_n = addr_lo_q;
        req_n     = req_q;
        we_n      = we_q;
        maddr_n   = maddr_q;
        mask_n    = mask_q;
        mwdata_n  = mwdata_q;
        done_n    = 1'b0;
        err_n     = err_q;
        rdata_n   = rdata_q;
        unique case (state)
            IDLE: begin
                if (bus.lsu_valid_in) begin
                    store_n   = bus.lsu_is_store_in;
                    funct3_n  = bus.lsu_funct3_in;
                    addr_lo_n = bus.lsu_addr_in[1:0];
                    if (illegal) begin
                        state_n = ERR;
                        done_n  = 1'b1;
                        err_n   = 2'b11;
                    end else if (misaligned) begin
                        state_n = ERR;
                        done_n  = 1'b1;
                        err_n   = 2'b01;
                    end else begin
                        state_n  = ACCESS;
                        cnt_n    = '0;
                        req_n    = 1'b1;
                        we_n     = bus.lsu_is_store_in;
                        maddr_n  = {bus.lsu_addr_in[31:2], 2'b00};
                        mask_n   = st_mask;
                        mwdata_n = st_data;
                    end
                end
            end
            ACCESS: begin
                // An ack in the last allowed cycle still completes normally.
                if (bus.mem_ack_in) begin
                    state_n = RESP;
                    req_n   = 1'b0;
                    done_n  = 1'b1;
                    err_n   = 2'b00;
                    rdata_n = store_q ? 32'h0 : load_ext;
                end else if (cnt == CNT_LAST) begin
                    state_n = RESP;
                    req_n   = 1'b0;
                    done_n  = 1'b1;
                    err_n   = 2'b10;
                    rdata_n = 32'h0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            RESP:    state_n = IDLE;
            ERR:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // State and output registers; reset abandons any access in flight.
    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (!ms_riscv32_mp_rst_n_in) begin
            state     <= IDLE;
            cnt       <= '0;
            store_q   <= 1'b0;
            funct3_q  <= 3'b000;
            addr_lo_q <= 2'b00;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            maddr_q   <= 32'h0;
            mask_q    <= 4'b0000;
            mwdata_q  <= 32'h0;
            done_q    <= 1'b0;
            err_q     <= 2'b00;
            rdata_q   <= 32'h0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            store_q   <= store_n;
            funct3_q  <= funct3_n;
            addr_lo_q <= addr_lo_n;
            req_q     <= req_n;
            we_q      <= we_n;
            maddr_q   <= maddr_n;
            mask_q    <= mask_n;
            mwdata_q  <= mwdata_n;
            done_q    <= done_n;
            err_q     <= err_n;
            rdata_q   <= rdata_n;
        end
    end

    assign bus.lsu_ready_out = (state == IDLE);
    assign bus.mem_req_out   = req_q;
    assign bus.mem_we_out    = we_q;
    assign bus.mem_addr_out  = maddr_q;
    assign bus.mem_wmask_out = mask_q;
    assign bus.mem_wdata_out = mwdata_q;
    assign bus.lsu_done_out  = done_q;
    assign bus.lsu_err_out   = err_q;
    assign bus.lsu_rdata_out = rdata_q;

endmodule
